// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gate controller: requests shutdown after IDLE_CYCLES idle cycles,
// gates on ack, and re-enables on wake with a WAKE_CYCLES settle delay. Optional macro: CLK_GATE_CTRL_FORCE_EN.
module clk_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2
) (
   input  logic clk_i,
   input  logic rst_an_i,
   input  logic busy_i,
   input  logic wake_i,
   input  logic off_ack_i,
`ifdef CLK_GATE_CTRL_FORCE_EN
   input  logic force_i,
`endif
   output logic ena_o,
   output logic off_req_o,
   output logic rdy_o
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_REQ  = 2'd1,
      ST_OFF  = 2'd2,
      ST_WAKE = 2'd3
   } state_t;

   localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
   localparam logic [3:0] WAKE_LOAD = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);

   state_t     state_r, state_nxt_s;
   logic [7:0] cnt_r, cnt_nxt_s;
   logic [3:0] wcnt_r, wcnt_nxt_s;
   logic       ena_r, rdy_r, off_req_r;
   logic       ena_nxt_s, rdy_nxt_s, off_req_nxt_s;
   logic       busy_s, wake_s, idle_s;

`ifdef CLK_GATE_CTRL_FORCE_EN
   // Debug/scan override looks like a busy, waking consumer in every state.
   assign busy_s = busy_i | force_i;
   assign wake_s = wake_i | force_i;
`else
   assign busy_s = busy_i;
   assign wake_s = wake_i;
`endif
   assign idle_s = !busy_s && !wake_s;

   // Next-state, counter and output decode.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = 8'd0;
      wcnt_nxt_s    = wcnt_r;
      case (state_r)
         ST_RUN: begin
            if (idle_s) begin
               if (cnt_r == IDLE_LAST) begin
                  state_nxt_s = ST_REQ;
                  cnt_nxt_s   = 8'd0;
               end else begin
                  cnt_nxt_s   = cnt_r + 8'd1;
               end
            end else begin
               cnt_nxt_s = 8'd0;
            end
         end
         ST_REQ: begin
            // Abort wins over a simultaneous acknowledge.
            if (busy_s || wake_s) begin
               state_nxt_s = ST_RUN;
            end else if (off_ack_i) begin
               state_nxt_s = ST_OFF;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_OFF: begin
            if (wake_s) begin
               if (WAKE_CYCLES == 0) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_WAKE;
                  wcnt_nxt_s  = WAKE_LOAD;
               end
            end else begin
               state_nxt_s = ST_OFF;
            end
         end
         ST_WAKE: begin
            if (wcnt_r == 4'd0) begin
               state_nxt_s = ST_RUN;
            end else begin
               wcnt_nxt_s  = wcnt_r - 4'd1;
            end
         end
         default: begin
            state_nxt_s = ST_RUN;
            wcnt_nxt_s  = 4'd0;
         end
      endcase

      ena_nxt_s     = (state_nxt_s != ST_OFF);
      rdy_nxt_s     = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_REQ);
      off_req_nxt_s = (state_nxt_s == ST_REQ);
   end

   // State, counters and registered outputs; reset re-enables the clock at once.
   always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
         state_r   <= ST_RUN;
         cnt_r     <= 8'd0;
         wcnt_r    <= 4'd0;
         ena_r     <= 1'b1;
         rdy_r     <= 1'b1;
         off_req_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         wcnt_r    <= wcnt_nxt_s;
         ena_r     <= ena_nxt_s;
         rdy_r     <= rdy_nxt_s;
         off_req_r <= off_req_nxt_s;
      end
   end

   assign ena_o     = ena_r;
   assign rdy_o     = rdy_r;
   assign off_req_o = off_req_r;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (IDLE_CYCLES=16, WAKE_CYCLES=2).
module tb_clk_gate_ctrl;

   logic clk = 1'b0;
   logic rst_an = 1'b0;
   logic busy = 1'b0;
   logic wake = 1'b0;
   logic off_ack = 1'b0;
`ifdef CLK_GATE_CTRL_FORCE_EN
   logic force_s = 1'b0;
`endif
   logic ena, off_req, rdy;
   int   n_checks = 0;
   int   n_fail = 0;

   clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut (
      .clk_i(clk),
      .rst_an_i(rst_an),
      .busy_i(busy),
      .wake_i(wake),
      .off_ack_i(off_ack),
`ifdef CLK_GATE_CTRL_FORCE_EN
      .force_i(force_s),
`endif
      .ena_o(ena),
      .off_req_o(off_req),
      .rdy_o(rdy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_an = 1'b0;
      tick();
      n_checks++;
      if ({ena, rdy, off_req} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_out: got ena/rdy/req=%b want 110", {ena, rdy, off_req});
      end
   endtask

   // From RUN with cnt=0, drive n idle cycles; off_req must rise exactly on the 16th.
   task automatic idle_run(input string name, input int n);
      busy = 1'b0;
      wake = 1'b0;
      for (int k = 1; k <= n; k++) begin
         tick();
         n_checks++;
         if (off_req !== (k >= 16) || ena !== 1'b1 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got req/ena/rdy=%b%b%b want %b11",
                     name, k, off_req, ena, rdy, (k >= 16));
         end
      end
   endtask

   task automatic test_idle_to_req();
      rst_an = 1'b1;
      idle_run("idle_to_req", 16);
   endtask

   task automatic test_ack_wake_abort();
      off_ack = 1'b1;
      wake = 1'b1;
      tick();
      n_checks++;
      if ({ena, rdy, off_req} !== 3'b110) begin
         n_fail++;
         $display("FAIL abort_priority: got ena/rdy/req=%b want 110", {ena, rdy, off_req});
      end
      off_ack = 1'b0;
      wake = 1'b0;
   endtask

   task automatic test_restart();
      idle_run("restart_pre", 10);
      busy = 1'b1;
      tick();
      n_checks++;
      if (off_req !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_busy: got req=%b want 0", off_req);
      end
      idle_run("restart_post", 16);
   endtask

   task automatic test_off_wake();
      off_ack = 1'b1;
      tick();
      off_ack = 1'b0;
      n_checks++;
      if ({ena, rdy, off_req} !== 3'b000) begin
         n_fail++;
         $display("FAIL ack_to_off: got ena/rdy/req=%b want 000", {ena, rdy, off_req});
      end
      busy = 1'b1;
      off_ack = 1'b1;
      tick();
      tick();
      busy = 1'b0;
      off_ack = 1'b0;
      n_checks++;
      if ({ena, rdy, off_req} !== 3'b000) begin
         n_fail++;
         $display("FAIL off_hold: got ena/rdy/req=%b want 000", {ena, rdy, off_req});
      end
      wake = 1'b1;
      tick();
      wake = 1'b0;
      n_checks++;
      if ({ena, rdy} !== 2'b10) begin
         n_fail++;
         $display("FAIL wake_ena: got ena/rdy=%b want 10", {ena, rdy});
      end
      tick();
      n_checks++;
      if ({ena, rdy} !== 2'b10) begin
         n_fail++;
         $display("FAIL wake_settle1: got ena/rdy=%b want 10", {ena, rdy});
      end
      tick();
      n_checks++;
      if ({ena, rdy, off_req} !== 3'b110) begin
         n_fail++;
         $display("FAIL wake_rdy: got ena/rdy/req=%b want 110", {ena, rdy, off_req});
      end
   endtask

   task automatic test_reset_in_off();
      idle_run("to_req2", 16);
      off_ack = 1'b1;
      tick();
      off_ack = 1'b0;
      n_checks++;
      if (ena !== 1'b0) begin
         n_fail++;
         $display("FAIL off_again: got ena=%b want 0", ena);
      end
      #2;
      rst_an = 1'b0;
      #1;
      n_checks++;
      if ({ena, rdy, off_req} !== 3'b110) begin
         n_fail++;
         $display("FAIL async_reset: got ena/rdy/req=%b want 110", {ena, rdy, off_req});
      end
      tick();
      rst_an = 1'b1;
   endtask

`ifdef CLK_GATE_CTRL_FORCE_EN
   task automatic test_force();
      idle_run("force_to_req", 16);
      off_ack = 1'b1;
      tick();
      off_ack = 1'b0;
      force_s = 1'b1;
      tick();
      n_checks++;
      if ({ena, rdy} !== 2'b10) begin
         n_fail++;
         $display("FAIL force_wake: got ena/rdy=%b want 10", {ena, rdy});
      end
      for (int k = 0; k < 100; k++) begin
         tick();
         n_checks++;
         if (off_req !== 1'b0) begin
            n_fail++;
            $display("FAIL force_hold cycle %0d: got req=%b want 0", k, off_req);
         end
      end
      force_s = 1'b0;
      idle_run("force_release", 16);
   endtask
`endif

   initial begin
      test_reset();
      test_idle_to_req();
      test_ack_wake_abort();
      test_restart();
      test_off_wake();
      test_reset_in_off();
`ifdef CLK_GATE_CTRL_FORCE_EN
      test_force();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
